// File: rtl/boss_pkg.sv
// rtl/boss_pkg.sv - shared boss stage types and constants
// Purpose: boss life-cycle state type, default hit-point constants shared with
//          the boss block and score logic, and small elaboration-time helpers.
// Ports:   none (package)
package boss_pkg;

  typedef enum logic [1:0] {
    BOSS_ALIVE,
    BOSS_INVULN,
    BOSS_DYING,
    BOSS_DEAD
  } boss_state_t;

  localparam int BOSS_MAX_HP    = 20;
  localparam int BOSS_ENRAGE_HP = 8;

  function automatic int boss_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Last counter value of a frame-delay state; a 0-frame delay still lasts one frame.
  function automatic int boss_last(input int frames);
    return (frames <= 1) ? 0 : frames - 1;
  endfunction

endpackage

// File: rtl/boss_health.sv
// rtl/boss_health.sv - boss hit-point tracker and life-cycle FSM
// Purpose: latches at most one missile hit per video frame, applies damage on
//          the frame tick, and walks ALIVE -> INVULN / DYING -> DEAD.
// Optional feature: BOSS_HIT_FLASH_EN enables the damage-flash output;
//          when undefined, flash is tied low.
// Ports:
//   clk              in   system clock
//   reset            in   asynchronous active-high reset
//   enable           in   stage active; low freezes FSM and ignores hits
//   startOfFrame     in   one-cycle pulse per video frame
//   missile_hit      in   missile pixel overlaps boss pixel
//   hp               out  remaining hit points
//   boss_is_hit      out  boss is DYING or DEAD
//   boss_enraged     out  ALIVE/INVULN with 0 < hp <= ENRAGE_HP
//   boss_deactivated out  boss is DEAD
//   flash            out  damage-flash request to bitmap
module boss_health
  import boss_pkg::*;
#(
  parameter int MAX_HP        = BOSS_MAX_HP,
  parameter int HP_WIDTH      = 8,
  parameter int HIT_DAMAGE    = 1,
  parameter int INVULN_FRAMES = 8,
  parameter int ENRAGE_HP     = BOSS_ENRAGE_HP,
  parameter int DEATH_FRAMES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                startOfFrame,
  input  logic                missile_hit,
  output logic [HP_WIDTH-1:0] hp,
  output logic                boss_is_hit,
  output logic                boss_enraged,
  output logic                boss_deactivated,
  output logic                flash
);

  localparam int CNT_W = $clog2(boss_max(INVULN_FRAMES, DEATH_FRAMES)) + 1;

  localparam logic [CNT_W-1:0]    INV_LAST   = CNT_W'(boss_last(INVULN_FRAMES));
  localparam logic [CNT_W-1:0]    DEATH_LAST = CNT_W'(boss_last(DEATH_FRAMES));
  localparam logic [HP_WIDTH-1:0] HP_INIT    = HP_WIDTH'(MAX_HP);
  localparam logic [HP_WIDTH-1:0] HP_DMG     = HP_WIDTH'(HIT_DAMAGE);
  localparam logic [HP_WIDTH-1:0] HP_ENRAGE  = HP_WIDTH'(ENRAGE_HP);

  boss_state_t         r_state;
  boss_state_t         w_state_nxt;
  logic [HP_WIDTH-1:0] r_hp;
  logic [HP_WIDTH-1:0] w_hp_nxt;
  logic [HP_WIDTH-1:0] w_hp_sub;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_hit_pending;
  logic                r_is_hit;
  logic                r_enraged;
  logic                r_deact;
  logic                w_frame_tick;
  logic                w_hit_set;

  assign w_frame_tick = startOfFrame & enable;
  assign w_hit_set    = missile_hit & enable & (r_state == BOSS_ALIVE);

  // Saturating subtract: damage larger than remaining hp lands on zero.
  assign w_hp_sub = (r_hp > HP_DMG) ? (r_hp - HP_DMG) : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_hp_nxt    = r_hp;
    w_cnt_nxt   = r_cnt;
    if (w_frame_tick) begin
      case (r_state)
        BOSS_ALIVE: begin
          if (r_hit_pending) begin
            w_hp_nxt    = w_hp_sub;
            w_cnt_nxt   = '0;
            w_state_nxt = (w_hp_sub == '0) ? BOSS_DYING : BOSS_INVULN;
          end
        end
        BOSS_INVULN: begin
          if (r_cnt == INV_LAST) begin
            w_state_nxt = BOSS_ALIVE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        BOSS_DYING: begin
          if (r_cnt == DEATH_LAST) begin
            w_state_nxt = BOSS_DEAD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Flags are computed from the next state so they move together with hp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= BOSS_ALIVE;
      r_hp          <= HP_INIT;
      r_cnt         <= '0;
      r_hit_pending <= 1'b0;
      r_is_hit      <= 1'b0;
      r_enraged     <= 1'b0;
      r_deact       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hp    <= w_hp_nxt;
      r_cnt   <= w_cnt_nxt;
      // A hit on the tick cycle belongs to the new frame, so set wins over clear.
      if (w_hit_set) begin
        r_hit_pending <= 1'b1;
      end else if (w_frame_tick) begin
        r_hit_pending <= 1'b0;
      end
      r_is_hit  <= (w_state_nxt == BOSS_DYING) || (w_state_nxt == BOSS_DEAD);
      r_enraged <= ((w_state_nxt == BOSS_ALIVE) || (w_state_nxt == BOSS_INVULN)) &&
                   (w_hp_nxt != '0) && (w_hp_nxt <= HP_ENRAGE);
      r_deact   <= (w_state_nxt == BOSS_DEAD);
    end
  end

`ifdef BOSS_HIT_FLASH_EN
  logic r_flash;

  // Blink on even invulnerability frames, solid while dying.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flash <= 1'b0;
    end else begin
      r_flash <= ((w_state_nxt == BOSS_INVULN) && !w_cnt_nxt[0]) ||
                 (w_state_nxt == BOSS_DYING);
    end
  end

  assign flash = r_flash;
`else
  assign flash = 1'b0;
`endif

  assign hp               = r_hp;
  assign boss_is_hit      = r_is_hit;
  assign boss_enraged     = r_enraged;
  assign boss_deactivated = r_deact;

endmodule

// File: tb/tb_boss_health.sv
// tb/tb_boss_health.sv - self-checking bench for boss_health
module tb_boss_health;
  import boss_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       sof;
  logic       missile_hit;
  logic [7:0] hp, hp2;
  logic       is_hit, enr, deact, flash;
  logic       is_hit2, enr2, deact2, flash2;

`ifdef BOSS_HIT_FLASH_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  always #5 clk = ~clk;

  boss_health u_dut (
    .clk(clk), .reset(reset), .enable(enable), .startOfFrame(sof),
    .missile_hit(missile_hit), .hp(hp), .boss_is_hit(is_hit),
    .boss_enraged(enr), .boss_deactivated(deact), .flash(flash)
  );

  // Small boss with heavy damage and zero-length invulnerability.
  boss_health #(.MAX_HP(3), .HIT_DAMAGE(2), .INVULN_FRAMES(0)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .startOfFrame(sof),
    .missile_hit(missile_hit), .hp(hp2), .boss_is_hit(is_hit2),
    .boss_enraged(enr2), .boss_deactivated(deact2), .flash(flash2)
  );

  typedef struct packed {
    logic [7:0] hp;
    logic       is_hit;
    logic       enr;
    logic       deact;
    logic       flash;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  boss_state_t m_state;
  int          m_hp;
  int          m_cnt;
  bit          m_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = BOSS_ALIVE;
    m_hp    = 20;
    m_cnt   = 0;
    m_pend  = 0;
  endtask

  function automatic exp_t model_out();
    exp_t o;
    o.hp     = 8'(m_hp);
    o.is_hit = (m_state == BOSS_DYING) || (m_state == BOSS_DEAD);
    o.enr    = ((m_state == BOSS_ALIVE) || (m_state == BOSS_INVULN)) && (m_hp > 0) && (m_hp <= 8);
    o.deact  = (m_state == BOSS_DEAD);
    o.flash  = FL & (((m_state == BOSS_INVULN) && (m_cnt % 2 == 0)) || (m_state == BOSS_DYING));
    return o;
  endfunction

  // Frames remaining drive the model: INVULN lasts 8 ticks, DYING 10 ticks.
  task automatic model_tick(input bit hit_now);
    boss_state_t old;
    old = m_state;
    case (m_state)
      BOSS_ALIVE: if (m_pend) begin
        m_hp    = (m_hp > 1) ? m_hp - 1 : 0;
        m_cnt   = 0;
        m_state = (m_hp == 0) ? BOSS_DYING : BOSS_INVULN;
      end
      BOSS_INVULN: begin
        m_cnt = m_cnt + 1;
        if (m_cnt == 8) begin m_state = BOSS_ALIVE; m_cnt = 0; end
      end
      BOSS_DYING: begin
        m_cnt = m_cnt + 1;
        if (m_cnt == 10) begin m_state = BOSS_DEAD; m_cnt = 0; end
      end
      default: ;
    endcase
    m_pend = hit_now && (old == BOSS_ALIVE);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hits(input int n);
    @(negedge clk);
    missile_hit = 1'b1;
    if (enable && m_state == BOSS_ALIVE) m_pend = 1;
    repeat (n) @(negedge clk);
    missile_hit = 1'b0;
  endtask

  // One startOfFrame pulse; expected outputs queued on drive, checked a cycle later.
  task automatic frame(input bit hit_now);
    exp_t e;
    @(negedge clk);
    sof         = 1'b1;
    missile_hit = hit_now;
    if (enable) begin
      model_tick(hit_now);
      sb.push_back(model_out());
    end
    @(negedge clk);
    sof         = 1'b0;
    missile_hit = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_hp", hp, e.hp);
      chk("sb_boss_is_hit", is_hit, e.is_hit);
      chk("sb_enraged", enr, e.enr);
      chk("sb_deactivated", deact, e.deact);
      chk("sb_flash", flash, e.flash);
    end
  endtask

  task automatic kill_boss();
    while (m_hp > 0) begin
      hits(2);
      frame(0);
      if (m_hp == 9) chk("t4_not_enraged_at_9", enr, 0);
      if (m_hp == 8) chk("t4_enraged_at_8", enr, 1);
      if (m_hp > 0) repeat (8) frame(0);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; sof = 1'b0; missile_hit = 1'b0;
    model_reset();
    idle(3);
    chk("rst_hp", hp, 20);
    chk("rst_is_hit", is_hit, 0);
    chk("rst_enraged", enr, 0);
    chk("rst_deact", deact, 0);
    chk("rst_flash", flash, 0);
    chk("rst_sat_hp", hp2, 3);
    reset = 1'b0;

    // No hits for 50 frames.
    repeat (50) begin idle(3); frame(0); end
    chk("t1_hp", hp, 20);

    // Long overlap within one frame counts once.
    hits(300);
    frame(0);
    chk("t2_hp", hp, 19);
    chk("t2_flash_first", flash, FL);
    chk("t2_sat_hp", hp2, 1);
    repeat (8) begin hits(5); frame(0); end
    chk("t2_invuln_hp", hp, 19);
    chk("t2_sat_floor_hp", hp2, 0);
    chk("t2_sat_is_hit", is_hit2, 1);
    frame(0);
    chk("t2_no_stale_hit", hp, 19);

    // Hit coincident with the tick applies at the following tick.
    frame(1);
    chk("t5_coincident_hp", hp, 19);
    frame(0);
    chk("t5_next_tick_hp", hp, 18);
    repeat (8) frame(0);

    // Disabled: hits and ticks ignored.
    enable = 1'b0;
    hits(5);
    repeat (3) frame(1);
    chk("t5_disabled_hp", hp, 18);
    chk("t5_disabled_is_hit", is_hit, 0);
    enable = 1'b1;
    frame(0);
    chk("t5_reenabled_hp", hp, 18);

    // Pending hit survives a disabled stretch.
    hits(3);
    enable = 1'b0;
    repeat (2) frame(0);
    enable = 1'b1;
    frame(0);
    chk("t5_pending_kept_hp", hp, 17);
    repeat (8) frame(0);

    // Run down to zero, then death delay.
    kill_boss();
    chk("t3_hp_zero", hp, 0);
    chk("t3_is_hit", is_hit, 1);
    chk("t4_enrage_falls", enr, 0);
    repeat (9) frame(0);
    chk("t3_not_yet_dead", deact, 0);
    frame(0);
    chk("t3_dead", deact, 1);
    repeat (3) begin hits(5); frame(0); end
    chk("t3_dead_hp_floor", hp, 0);
    chk("t3_dead_stays", deact, 1);

    // Asynchronous reset in the middle of DYING.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    kill_boss();
    repeat (5) frame(0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_hp", hp, 20);
    chk("t6_async_is_hit", is_hit, 0);
    chk("t6_async_enraged", enr, 0);
    chk("t6_async_flash", flash, 0);
    @(negedge clk); reset = 1'b0;
    model_reset();

    // Flash pattern across the first INVULN frames.
    hits(2);
    frame(0);
    chk("t6_flash_cnt0", flash, FL);
    frame(0);
    chk("t6_flash_cnt1", flash, 0);
    frame(0);
    chk("t6_flash_cnt2", flash, FL);
    repeat (6) frame(0);
    chk("t6_hp_after", hp, 19);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
